// File: rtl/mem_access_responder.sv
// mem_access_responder
//   Coefficient store for an NTT engine. Reads are issued as bursts of
//   BURST_LEN words and return through a fixed RD_LAT-cycle pipeline. The
//   pipeline never stalls. Writes are accepted in any state and acknowledged
//   one cycle later. A burst walks IDLE -> STREAM -> DRAIN -> IDLE. Any read
//   request seen during DRAIN is dropped and sets a sticky error flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   r_enable/r_addr       read request (one word per cycle)
//   w_enable/w_addr/w_data write request
//   r_enable_out/r_data_out read data valid / data, RD_LAT cycles after request
//   w_enable_out          write acknowledge, one cycle after the write
//   stage_done            one-cycle pulse with the last return of a burst
//   ovr_err               sticky: a read was dropped during DRAIN
module mem_access_responder #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              r_enable_out,
  output logic [DATA_W-1:0] r_data_out,
  output logic              w_enable_out,
  output logic              stage_done,
  output logic              ovr_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               rd_cnt_q, rd_cnt_d;
  logic                           ovr_err_q, ovr_err_d;
  logic                           w_ack_q, w_ack_d;
  // Read return pipeline: valid, last-of-burst tag and data travel together.
  logic [RD_LAT-1:0]              vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0]              last_pipe_q, last_pipe_d;
  logic [RD_LAT-1:0][DATA_W-1:0]  dat_pipe_q, dat_pipe_d;

  logic [DATA_W-1:0]              mem [2**ADDR_W];
  logic                           rd_acc, rd_last;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_enable) mem[w_addr] <= w_data;
  end

  // Only the read that completes the burst is tagged, so the burst is done
  // exactly when that tag leaves the pipeline.
  assign stage_done = (state_q == DRAIN) && vld_pipe_q[RD_LAT-1] && last_pipe_q[RD_LAT-1];

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    ovr_err_d = ovr_err_q;
    rd_acc    = 1'b0;
    rd_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r_enable) begin
          rd_acc   = 1'b1;
          rd_cnt_d = CNT_W'(1);
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (r_enable) begin
          rd_acc = 1'b1;
          if (rd_cnt_q == CNT_W'(BURST_LEN - 1)) begin
            rd_last  = 1'b1;
            rd_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (r_enable)   ovr_err_d = 1'b1;
        if (stage_done) state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data is zeroed on empty slots so r_data_out reads 0 when not valid.
  // Reading mem here, before the write edge, gives read-old-on-collision.
  always_comb begin
    w_ack_d        = w_enable;
    vld_pipe_d     = vld_pipe_q;
    last_pipe_d    = last_pipe_q;
    dat_pipe_d     = dat_pipe_q;
    vld_pipe_d[0]  = rd_acc;
    last_pipe_d[0] = rd_last;
    dat_pipe_d[0]  = rd_acc ? mem[r_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
      dat_pipe_d[i]  = dat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      ovr_err_q   <= 1'b0;
      w_ack_q     <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      dat_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      ovr_err_q   <= ovr_err_d;
      w_ack_q     <= w_ack_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      dat_pipe_q  <= dat_pipe_d;
    end
  end

  assign r_enable_out = vld_pipe_q[RD_LAT-1];
  assign r_data_out   = dat_pipe_q[RD_LAT-1];
  assign w_enable_out = w_ack_q;
  assign ovr_err      = ovr_err_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// Bench for mem_access_responder: scoreboarded read returns (due cycle + data),
// per-cycle checks of stage_done, write ack and ovr_err against a small model,
// a table of read/write collision vectors, and hand-written burst/reset cases.
module tb_mem_access_responder;
  localparam int DATA_W = 64, ADDR_W = 8, RD_LAT = 2, BURST_LEN = 16;

  logic              clk, rst_n, r_enable, w_enable;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] w_data, r_data_out;
  logic              r_enable_out, w_enable_out, stage_done, ovr_err;

  mem_access_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_enable(r_enable), .r_addr(r_addr),
    .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .r_enable_out(r_enable_out), .r_data_out(r_data_out),
    .w_enable_out(w_enable_out), .stage_done(stage_done), .ovr_err(ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [DATA_W-1:0] data; } exp_t;
  typedef struct {
    logic re; logic [ADDR_W-1:0] ra;
    logic we; logic [ADDR_W-1:0] wa; logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rexp;
  } vec_t;

  exp_t              sbq[$];
  logic [DATA_W-1:0] mdl_mem [2**ADDR_W];
  vec_t              tbl [7];
  int   checks = 0, errors = 0, cyc = 0;
  int   brd = 0, done_due = -1, drain_until = -1;
  logic ovr_exp = 1'b0, wack_exp = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    if (!rst_n) begin
      chk("rst_rvalid", 64'(r_enable_out), 64'(0));
      chk("rst_rdata",  r_data_out,         64'(0));
      chk("rst_wack",   64'(w_enable_out), 64'(0));
      chk("rst_done",   64'(stage_done),   64'(0));
      chk("rst_ovr",    64'(ovr_err),      64'(0));
      return;
    end
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      chk("missed_return_now_vs_due", 64'(cyc), 64'(e.due));
    end
    if (r_enable_out) begin
      if (sbq.size() == 0) chk("unexpected_return", 64'(r_enable_out), 64'(0));
      else begin
        e = sbq.pop_front();
        chk("return_cycle", 64'(cyc), 64'(e.due));
        chk("return_data",  r_data_out, e.data);
      end
    end
    chk("stage_done", 64'(stage_done),   64'(cyc == done_due));
    chk("w_ack",      64'(w_enable_out), 64'(wack_exp));
    chk("ovr_err",    64'(ovr_err),      64'(ovr_exp));
  endtask

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic re, input logic [ADDR_W-1:0] ra, input logic we,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] rexp);
    logic acc;
    acc = re && (cyc > drain_until);
    r_enable = re; r_addr = ra; w_enable = we; w_addr = wa; w_data = wd;
    if (acc) begin
      sbq.push_back('{due: cyc + RD_LAT, data: rexp});
      brd++;
      if (brd == BURST_LEN) begin
        done_due    = cyc + RD_LAT;
        drain_until = done_due;
        brd         = 0;
      end
    end
    if (we) mdl_mem[wa] = wd;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    wack_exp = we;
    #1;
    if (re && !acc) ovr_exp = 1'b1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    drive(1'b1, a, 1'b0, '0, '0, mdl_mem[a]);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    drive(1'b0, '0, 1'b1, a, d, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // Reset dropped mid-cycle: outputs must be zero before the next edge.
  task automatic reset_pulse();
    rst_n = 1'b0; r_enable = 1'b0; w_enable = 1'b0;
    sbq.delete();
    brd = 0; done_due = -1; drain_until = -1; ovr_exp = 1'b0; wack_exp = 1'b0;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{re:1'b0, ra:8'd0, we:1'b1, wa:8'd5, wd:64'h55,   rexp:64'h0};
    tbl[1] = '{re:1'b1, ra:8'd5, we:1'b1, wa:8'd5, wd:64'hAA,   rexp:64'h55};
    tbl[2] = '{re:1'b1, ra:8'd5, we:1'b0, wa:8'd0, wd:64'h0,    rexp:64'hAA};
    tbl[3] = '{re:1'b1, ra:8'd7, we:1'b1, wa:8'd7, wd:64'h1234, rexp:64'd107};
    tbl[4] = '{re:1'b1, ra:8'd7, we:1'b0, wa:8'd0, wd:64'h0,    rexp:64'h1234};
    tbl[5] = '{re:1'b1, ra:8'd5, we:1'b1, wa:8'd9, wd:64'h99,   rexp:64'hAA};
    tbl[6] = '{re:1'b1, ra:8'd9, we:1'b0, wa:8'd0, wd:64'h0,    rexp:64'h99};

    rst_n = 1'b0; r_enable = 1'b0; w_enable = 1'b0;
    r_addr = '0; w_addr = '0; w_data = '0;
    repeat (3) begin
      @(negedge clk); check_cycle();
      @(posedge clk); cyc++;
    end
    #1 rst_n = 1'b1;
    idle(1);

    // Preload: 0..15 -> 100..115, 16..31 -> 3i+7.
    for (int i = 0; i < 32; i++)
      wr(ADDR_W'(i), (i < 16) ? 64'(100 + i) : 64'(3 * i + 7));
    idle(2);

    // Back-to-back burst; the next burst starts right after stage_done,
    // which is only accepted if the FSM is back in IDLE.
    for (int i = 0; i < 16; i++) rd(ADDR_W'(i));
    idle(2);
    // Burst with a gap after every request.
    for (int i = 0; i < 16; i++) begin rd(ADDR_W'(16 + i)); idle(1); end
    idle(3);

    // Collision table: same-cycle read/write returns old data, next read new.
    for (int i = 0; i < 7; i++)
      drive(tbl[i].re, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rexp);
    for (int i = 0; i < 10; i++) rd(ADDR_W'(10 + i));
    idle(4);

    // Request during DRAIN is dropped and latches ovr_err.
    for (int i = 0; i < 16; i++) rd(ADDR_W'(i));
    rd(8'd3);
    idle(6);

    // Reset after the 10th read (with a pending write ack); nothing in flight
    // may surface, ovr_err clears, storage survives.
    for (int i = 0; i < 9; i++) rd(ADDR_W'(i));
    drive(1'b1, 8'd9, 1'b1, 8'd40, 64'h4040, mdl_mem[9]);
    reset_pulse();
    idle(6);
    for (int i = 0; i < 16; i++) rd(ADDR_W'(i));
    rd(8'd40);
    idle(RD_LAT + 3);

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
